imem_axi_rd_resp: RTL and testbench

AXI4 read-channel responder (slave) serving 64-bit instruction beats to the fetch-side AXI read receiver. It accepts one AR request at a time and issues INCR bursts of up to 256 beats from a synchronous single-port instruction memory with 1-cycle read latency. Each beat is returned on the R channel with RRESP and RLAST. A 2-entry output buffer absorbs RREADY backpressure without losing memory data. It sits in the axi_clk domain, on the memory side of the fetch async FIFO.

---
 rtl/imem_axi_rd_resp.sv | 173 +++++++++++++++++
 tb/tb_imem_axi_rd_resp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_axi_rd_resp.sv
// AXI4 read responder: serves INCR bursts of 64-bit beats from a 1-cycle-latency
// instruction memory, with a 2-entry output buffer absorbing RREADY backpressure.
module imem_axi_rd_resp #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 4096,
    parameter int MEM_AW    = 12
) (
    input  logic              axi_clk,
    input  logic              axi_resetn,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [7:0]        arlen_i,
    input  logic [2:0]        arsize_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [63:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              mem_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [63:0]       mem_rdata_i
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_WORDS * 8);

    state_t            state;
    logic              arready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        issue_idx;
    logic [8:0]        issue_left;
    logic              req_err_q;

    logic              inflight_q;
    logic              infl_err_q;
    logic              infl_last_q;

    logic [63:0]       buf_data [2];
    logic [1:0]        buf_resp [2];
    logic              buf_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_count;

    logic [1:0]        occupancy;
    logic              issue;
    logic              beat_err;
    logic              r_fire;
    logic              push;
    logic              pop;
    logic [63:0]       infl_data;
    logic [1:0]        infl_resp;

    assign arready_o  = arready_q;

    // Buffered beats plus the one returning from memory must never exceed two.
    assign occupancy  = buf_count + {1'b0, inflight_q};
    assign issue      = (state == BURST) && (issue_left != 9'd0) && (occupancy < 2'd2);
    assign beat_err   = req_err_q || ({1'b0, addr_q} >= MEM_BYTES);
    assign mem_en_o   = issue && !beat_err;
    assign mem_addr_o = mem_en_o ? addr_q[MEM_AW+2:3] : '0;

    assign infl_data  = infl_err_q ? 64'd0 : mem_rdata_i;
    assign infl_resp  = infl_err_q ? 2'b10 : 2'b00;

    // Head of the buffer, falling through to the returning beat when empty.
    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        rresp_o  = '0;
        rlast_o  = 1'b0;
        if (buf_count != 2'd0) begin
            rvalid_o = 1'b1;
            rdata_o  = buf_data[rd_ptr];
            rresp_o  = buf_resp[rd_ptr];
            rlast_o  = buf_last[rd_ptr];
        end else if (inflight_q) begin
            rvalid_o = 1'b1;
            rdata_o  = infl_data;
            rresp_o  = infl_resp;
            rlast_o  = infl_last_q;
        end
    end

    assign r_fire = rvalid_o && rready_i;
    assign pop    = r_fire && (buf_count != 2'd0);
    assign push   = inflight_q && ((buf_count != 2'd0) || !rready_i);

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state      <= IDLE;
            arready_q  <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            issue_idx  <= '0;
            issue_left <= '0;
            req_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid_i && arready_q) begin
                        state      <= BURST;
                        arready_q  <= 1'b0;
                        addr_q     <= araddr_i;
                        len_q      <= arlen_i;
                        issue_idx  <= '0;
                        issue_left <= {1'b0, arlen_i} + 9'd1;
                        req_err_q  <= (araddr_i[2:0] != 3'b000) || (arsize_i != 3'b011) ||
                                      (arburst_i != 2'b01);
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                BURST: begin
                    if (issue) begin
                        addr_q     <= addr_q + ADDR_W'(8);
                        issue_left <= issue_left - 9'd1;
                        issue_idx  <= issue_idx + 8'd1;
                    end
                    if (r_fire && rlast_o) begin
                        state     <= IDLE;
                        arready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            inflight_q  <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            inflight_q  <= issue;
            infl_err_q  <= issue && beat_err;
            infl_last_q <= issue && (issue_idx == len_q);
        end
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_resp[i] <= '0;
                buf_last[i] <= 1'b0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= infl_data;
                buf_resp[wr_ptr] <= infl_resp;
                buf_last[wr_ptr] <= infl_last_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_axi_rd_resp.sv
// Self-checking bench for imem_axi_rd_resp: directed and random bursts checked
// against a per-burst expected-beat list built from the memory contents.
module tb_imem_axi_rd_resp;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 4096;
    localparam int MEM_AW    = 12;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic              axi_clk = 1'b0;
    logic              axi_resetn = 1'b0;
    logic [ADDR_W-1:0] araddr_i = '0;
    logic [7:0]        arlen_i = '0;
    logic [2:0]        arsize_i = '0;
    logic [1:0]        arburst_i = '0;
    logic              arvalid_i = 1'b0;
    logic              arready_o;
    logic [63:0]       rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i = 1'b0;
    logic              mem_en_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [63:0]       mem_rdata_i = '0;

    imem_axi_rd_resp #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_AW(MEM_AW)) dut (
        .axi_clk     (axi_clk),
        .axi_resetn  (axi_resetn),
        .araddr_i    (araddr_i),
        .arlen_i     (arlen_i),
        .arsize_i    (arsize_i),
        .arburst_i   (arburst_i),
        .arvalid_i   (arvalid_i),
        .arready_o   (arready_o),
        .rdata_o     (rdata_o),
        .rresp_o     (rresp_o),
        .rlast_o     (rlast_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 axi_clk = ~axi_clk;

    logic [63:0] mem [MEM_WORDS];
    always @(posedge axi_clk) if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];

    beat_t             exp_q[$];
    logic [MEM_AW-1:0] exp_addr_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    issued = 0;
    int    accepted = 0;
    int    hs_cyc = -1;
    int    first_en = -1;
    int    first_rv = -1;
    int    last_cyc = -1;
    int    rr_mode = 0;
    int    rr_idx = 0;
    int    b2b_count = 0;
    bit    hs = 0;
    bit    in_burst = 0;
    bit    last_prev = 0;
    bit    stall_prev = 0;
    beat_t prev_beat;
    bit    rr_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: every beat of a request, straight from the AXI/range rules.
    task automatic push_expect(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        bit          rerr;
        bit          e;
        logic [31:0] a;
        beat_t       b;
        rerr = (addr[2:0] != 3'd0) || (size != 3'd3) || (burst != 2'd1);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(8 * i);
            e = rerr || (a >= 32'(MEM_WORDS * 8));
            b.data = e ? 64'd0 : mem[a[MEM_AW+2:3]];
            b.resp = e ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (!e) exp_addr_q.push_back(a[MEM_AW+2:3]);
        end
    endtask

    task automatic tick();
        beat_t b;
        bit    have;
        if (rr_mode == 0)      rready_i = 1'b1;
        else if (rr_mode == 1) rready_i = rr_pat[rr_idx % 6];
        else                   rready_i = ($urandom_range(0, 2) != 0);
        rr_idx++;
        @(negedge axi_clk);
        cyc++;
        if (in_burst)  check_output("arready_low_in_burst", arready_o, 0);
        if (last_prev) check_output("arready_after_last", arready_o, 1);
        if (stall_prev) begin
            check_output("stall_rvalid", rvalid_o, 1);
            check_output("stall_rdata", rdata_o, prev_beat.data);
            check_output("stall_rresp", rresp_o, prev_beat.resp);
            check_output("stall_rlast", rlast_o, prev_beat.last);
        end
        if (mem_en_o) begin
            check_output("issue_occupancy", (issued - accepted) < 2, 1);
            have = (exp_addr_q.size() != 0);
            check_output("mem_en_expected", have, 1);
            if (have) check_output("mem_addr", mem_addr_o, exp_addr_q.pop_front());
            if (first_en < 0) first_en = cyc;
            issued++;
        end
        if (rvalid_o && first_rv < 0) first_rv = cyc;
        last_prev = 0;
        if (rvalid_o && rready_i) begin
            have = (exp_q.size() != 0);
            check_output("beat_expected", have, 1);
            if (have) begin
                b = exp_q.pop_front();
                check_output("rdata", rdata_o, b.data);
                check_output("rresp", rresp_o, b.resp);
                check_output("rlast", rlast_o, b.last);
            end
            accepted++;
            if (rlast_o) begin
                last_prev = 1;
                in_burst  = 0;
                last_cyc  = cyc;
            end
        end
        stall_prev = rvalid_o && !rready_i;
        prev_beat  = {rdata_o, rresp_o, rlast_o};
        hs = arvalid_i && arready_o;
        if (hs) begin
            push_expect(araddr_i, arlen_i, arsize_i, arburst_i);
            in_burst = 1;
            hs_cyc   = cyc;
            first_en = -1;
            first_rv = -1;
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        araddr_i  = addr;
        arlen_i   = len;
        arsize_i  = size;
        arburst_i = burst;
        arvalid_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!hs && n < 50);
        arvalid_i = 1'b0;
        check_output("ar_accepted", hs, 1);
    endtask

    task automatic run_burst(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_burst) && n < budget) begin
            tick();
            n++;
        end
        check_output("burst_done_in_budget", (exp_q.size() == 0) && !in_burst, 1);
    endtask

    initial begin
        int          base;
        int          prev;
        int          n;
        int          kind;
        logic [31:0] ra;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = {$urandom, $urandom};

        #1;
        check_output("rst_arready", arready_o, 0);
        check_output("rst_rvalid", rvalid_o, 0);
        check_output("rst_rlast", rlast_o, 0);
        check_output("rst_rresp", rresp_o, 0);
        check_output("rst_rdata", rdata_o, 0);
        check_output("rst_mem_en", mem_en_o, 0);
        check_output("rst_mem_addr", mem_addr_o, 0);
        repeat (2) @(posedge axi_clk);
        #1 axi_resetn = 1'b1;
        tick();
        $display("[TB] reset released");

        // Aligned 4-beat burst, rready held high: latency and throughput.
        rr_mode = 0;
        apply_stimulus(32'h40, 8'd3, 3'd3, 2'd1);
        run_burst(100);
        check_output("lat_mem_en", first_en - hs_cyc, 1);
        check_output("lat_rvalid", first_rv - hs_cyc, 2);
        check_output("lat_last", last_cyc - hs_cyc, 5);
        tick();

        // Same burst under a toggling rready.
        rr_mode = 1;
        rr_idx  = 0;
        apply_stimulus(32'h40, 8'd3, 3'd3, 2'd1);
        run_burst(100);
        tick();

        // Misaligned request: all SLVERR, no memory reads.
        rr_mode = 0;
        apply_stimulus(32'h44, 8'd1, 3'd3, 2'd1);
        run_burst(100);
        check_output("misaligned_no_mem_en", first_en, -1);

        apply_stimulus(32'h80, 8'd2, 3'd2, 2'd1);
        run_burst(100);
        apply_stimulus(32'h80, 8'd1, 3'd3, 2'd2);
        run_burst(100);

        // Burst crossing the top of memory, and one wrapping the address space.
        apply_stimulus(32'h7FF0, 8'd3, 3'd3, 2'd1);
        run_burst(100);
        apply_stimulus(32'hFFFF_FFF8, 8'd2, 3'd3, 2'd1);
        run_burst(100);

        // Back-to-back single-beat requests with arvalid held.
        araddr_i  = 32'h200;
        arlen_i   = 8'd0;
        arsize_i  = 3'd3;
        arburst_i = 2'd1;
        arvalid_i = 1'b1;
        prev = -1;
        n    = 0;
        b2b_count = 0;
        while (b2b_count < 4 && n < 60) begin
            tick();
            n++;
            if (hs) begin
                if (prev >= 0) check_output("b2b_spacing", hs_cyc - prev, 3);
                prev = hs_cyc;
                b2b_count++;
                araddr_i = araddr_i + 32'd8;
            end
        end
        arvalid_i = 1'b0;
        check_output("b2b_count", b2b_count, 4);
        run_burst(100);
        tick();

        // Reset in the middle of an 8-beat burst.
        apply_stimulus(32'h300, 8'd7, 3'd3, 2'd1);
        base = accepted;
        n = 0;
        while (accepted - base < 2 && n < 50) begin
            tick();
            n++;
        end
        axi_resetn = 1'b0;
        #1;
        check_output("midrst_rvalid", rvalid_o, 0);
        check_output("midrst_mem_en", mem_en_o, 0);
        check_output("midrst_arready", arready_o, 0);
        exp_q.delete();
        exp_addr_q.delete();
        in_burst   = 0;
        stall_prev = 0;
        last_prev  = 0;
        issued     = 0;
        accepted   = 0;
        repeat (3) tick();
        axi_resetn = 1'b1;
        @(posedge axi_clk);
        #1;
        check_output("post_rst_arready", arready_o, 1);
        repeat (5) begin
            check_output("post_rst_no_beat", rvalid_o, 0);
            tick();
        end

        // Random bursts under random backpressure.
        rr_mode = 2;
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)       ra = {17'd0, 12'($urandom_range(0, MEM_WORDS - 1)), 3'd0};
            else if (kind < 8)  ra = 32'((MEM_WORDS - $urandom_range(1, 8)) * 8);
            else if (kind == 8) ra = {16'd0, 16'($urandom)} | 32'd1;
            else                ra = {$urandom} & 32'hFFFF_FFF8;
            apply_stimulus(ra, 8'($urandom_range(0, 15)),
                           ($urandom_range(0, 15) == 0) ? 3'd2 : 3'd3,
                           ($urandom_range(0, 15) == 0) ? 2'd0 : 2'd1);
            run_burst(400);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
